// File: rtl/dcache_mem_controller.sv
// Memory-side controller for dcache: round-robin grants of per-lane read/write
// requests onto a pool of memory channels, each running a 5-state handshake FSM.
module dcache_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                   mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                   mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_read_data,
  output logic [NUM_CHANNELS-1:0]                   mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                   mem_write_ready
);

  localparam int NUM_REQ  = 2 * NUM_CONSUMERS;
  localparam int REQ_BITS = $clog2(NUM_REQ);
  localparam logic [REQ_BITS:0] NUM_REQ_W = (REQ_BITS + 1)'(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } ch_state_t;

  ch_state_t               state_r [NUM_CHANNELS];
  ch_state_t               state_s [NUM_CHANNELS];
  logic [REQ_BITS-1:0]     req_r   [NUM_CHANNELS];
  logic [REQ_BITS-1:0]     req_s   [NUM_CHANNELS];
  logic [NUM_REQ-1:0]      claim_r, claim_s, pend_s, taken_s;
  logic [REQ_BITS-1:0]     rr_ptr_r, rr_ptr_s;
  logic [REQ_BITS-1:0]     scan_idx_s;
  logic [REQ_BITS:0]       scan_sum_s, next_sum_s;
  logic                    grant_found_s;

  logic [NUM_CONSUMERS-1:0]                 consumer_read_ready_s, consumer_write_ready_s;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data_s;
  logic [NUM_CHANNELS-1:0]                  mem_read_valid_s, mem_write_valid_s;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address_s, mem_write_address_s;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data_s;

  // Pending requestors: even index = read of slot r/2, odd index = write of slot r/2.
  always_comb begin
    pend_s = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (r % 2 == 0) begin
        pend_s[r] = consumer_read_valid[r/2] & ~claim_r[r] & ~consumer_read_ready[r/2];
      end else begin
        pend_s[r] = consumer_write_valid[r/2] & ~claim_r[r] & ~consumer_write_ready[r/2];
      end
    end
  end

  // Grant scan and per-channel FSM next state, including next output values.
  always_comb begin
    state_s                = state_r;
    req_s                  = req_r;
    claim_s                = claim_r;
    rr_ptr_s               = rr_ptr_r;
    taken_s                = '0;
    scan_idx_s             = '0;
    scan_sum_s             = '0;
    next_sum_s             = '0;
    grant_found_s          = 1'b0;
    consumer_read_ready_s  = consumer_read_ready;
    consumer_write_ready_s = consumer_write_ready;
    consumer_read_data_s   = consumer_read_data;
    mem_read_valid_s       = mem_read_valid;
    mem_read_address_s     = mem_read_address;
    mem_write_valid_s      = mem_write_valid;
    mem_write_address_s    = mem_write_address;
    mem_write_data_s       = mem_write_data;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      grant_found_s = 1'b0;
      case (state_r[c])
        IDLE: begin
          for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum_s = {1'b0, rr_ptr_r} + (REQ_BITS + 1)'(k);
            scan_idx_s = (scan_sum_s >= NUM_REQ_W) ? REQ_BITS'(scan_sum_s - NUM_REQ_W)
                                                   : REQ_BITS'(scan_sum_s);
            if (!grant_found_s && pend_s[scan_idx_s] && !taken_s[scan_idx_s]) begin
              grant_found_s       = 1'b1;
              taken_s[scan_idx_s] = 1'b1;
              claim_s[scan_idx_s] = 1'b1;
              req_s[c]            = scan_idx_s;
              next_sum_s          = {1'b0, scan_idx_s} + {{REQ_BITS{1'b0}}, 1'b1};
              rr_ptr_s            = (next_sum_s == NUM_REQ_W) ? '0 : next_sum_s[REQ_BITS-1:0];
              if (scan_idx_s[0] == 1'b0) begin
                state_s[c]            = READ_WAITING;
                mem_read_valid_s[c]   = 1'b1;
                mem_read_address_s[c] = consumer_read_address[scan_idx_s[REQ_BITS-1:1]];
              end else begin
                state_s[c]             = WRITE_WAITING;
                mem_write_valid_s[c]   = 1'b1;
                mem_write_address_s[c] = consumer_write_address[scan_idx_s[REQ_BITS-1:1]];
                mem_write_data_s[c]    = consumer_write_data[scan_idx_s[REQ_BITS-1:1]];
              end
            end else begin
              grant_found_s = grant_found_s;
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[c]) begin
            state_s[c]          = READ_RELAYING;
            mem_read_valid_s[c] = 1'b0;
            consumer_read_ready_s[req_r[c][REQ_BITS-1:1]] = 1'b1;
            consumer_read_data_s[req_r[c][REQ_BITS-1:1]]  = mem_read_data[c];
          end else begin
            state_s[c] = READ_WAITING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[c]) begin
            state_s[c]           = WRITE_RELAYING;
            mem_write_valid_s[c] = 1'b0;
            consumer_write_ready_s[req_r[c][REQ_BITS-1:1]] = 1'b1;
          end else begin
            state_s[c] = WRITE_WAITING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[req_r[c][REQ_BITS-1:1]]) begin
            state_s[c]          = IDLE;
            claim_s[req_r[c]]   = 1'b0;
            consumer_read_ready_s[req_r[c][REQ_BITS-1:1]] = 1'b0;
          end else begin
            state_s[c] = READ_RELAYING;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[req_r[c][REQ_BITS-1:1]]) begin
            state_s[c]          = IDLE;
            claim_s[req_r[c]]   = 1'b0;
            consumer_write_ready_s[req_r[c][REQ_BITS-1:1]] = 1'b0;
          end else begin
            state_s[c] = WRITE_RELAYING;
          end
        end
        default: begin
          state_s[c] = IDLE;
        end
      endcase
    end
  end

  // State, claim mask, round-robin pointer and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_r[c] <= IDLE;
        req_r[c]   <= '0;
      end
      claim_r                <= '0;
      rr_ptr_r               <= '0;
      consumer_read_ready    <= '0;
      consumer_write_ready   <= '0;
      consumer_read_data     <= '0;
      mem_read_valid         <= '0;
      mem_read_address       <= '0;
      mem_write_valid        <= '0;
      mem_write_address      <= '0;
      mem_write_data         <= '0;
    end else begin
      state_r                <= state_s;
      req_r                  <= req_s;
      claim_r                <= claim_s;
      rr_ptr_r               <= rr_ptr_s;
      consumer_read_ready    <= consumer_read_ready_s;
      consumer_write_ready   <= consumer_write_ready_s;
      consumer_read_data     <= consumer_read_data_s;
      mem_read_valid         <= mem_read_valid_s;
      mem_read_address       <= mem_read_address_s;
      mem_write_valid        <= mem_write_valid_s;
      mem_write_address      <= mem_write_address_s;
      mem_write_data         <= mem_write_data_s;
    end
  end

endmodule

// File: tb/tb_dcache_mem_controller.sv
// Directed bench for dcache_mem_controller: reset, single read, concurrent
// read/write, same-slot read+write, stalled memory and oversubscription.
module tb_dcache_mem_controller;

  logic                 clk;
  logic                 rst;
  logic [7:0]           crv, cwv, crr, cwr;
  logic [7:0][7:0]      cra, crd, cwa, cwd;
  logic [3:0]           mrv, mrr, mwv, mwr;
  logic [3:0][7:0]      mra, mrd, mwa, mwd;

  int vectors = 0;
  int errors  = 0;

  dcache_mem_controller #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4)
  ) dut (
    .clk(clk), .reset(rst),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    tick();
    #2 rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
    mrr = '0; mrd = '0; mwr = '0;
    tick();
    chk("rst_mrv", 64'(mrv), 64'h0);
    chk("rst_mwv", 64'(mwv), 64'h0);
    chk("rst_crr", 64'(crr), 64'h0);
    chk("rst_cwr", 64'(cwr), 64'h0);
    chk("rst_crd", 64'(crd), 64'h0);
    #2 rst = 1'b1;
    tick();

    // Reset while a read is waiting on memory
    crv[0] = 1'b1; cra[0] = 8'h10;
    tick();
    chk("a_mrv", 64'(mrv), 64'h1);
    chk("a_mra0", 64'(mra[0]), 64'h10);
    rst = 1'b0;
    #1;
    chk("a_mrv_async", 64'(mrv), 64'h0);
    chk("a_mra_async", 64'(mra[0]), 64'h0);
    #1 rst = 1'b1;
    tick();
    chk("a_regrant", 64'(mrv), 64'h1);
    chk("a_regrant_addr", 64'(mra[0]), 64'h10);
    mrr[0] = 1'b1; mrd[0] = 8'h77;
    tick();
    chk("a_crr", 64'(crr), 64'h01);
    chk("a_crd0", 64'(crd[0]), 64'h77);
    chk("a_mrv_drop", 64'(mrv), 64'h0);
    crv[0] = 1'b0; mrr[0] = 1'b0;
    tick();
    chk("a_release", 64'(crr), 64'h0);
    chk("a_data_hold", 64'(crd[0]), 64'h77);

    // Single read of 0xFF
    crv[0] = 1'b1; cra[0] = 8'hFF;
    tick();
    chk("b_mrv", 64'(mrv), 64'h1);
    chk("b_mra0", 64'(mra[0]), 64'hFF);
    chk("b_crr_wait", 64'(crr), 64'h0);
    mrr[0] = 1'b1; mrd[0] = 8'hFF;
    tick();
    chk("b_crr", 64'(crr), 64'h01);
    chk("b_crd0", 64'(crd[0]), 64'hFF);
    chk("b_mrv_drop", 64'(mrv), 64'h0);
    mrr[0] = 1'b0;
    tick();
    chk("b_hold_ready", 64'(crr), 64'h01);
    crv[0] = 1'b0;
    tick();
    chk("b_release", 64'(crr), 64'h0);

    // Concurrent read slot0 and write slot1 from a fresh round-robin pointer
    pulse_reset();
    crv[0] = 1'b1; cra[0] = 8'hFF;
    cwv[1] = 1'b1; cwa[1] = 8'hF0; cwd[1] = 8'hF0;
    tick();
    chk("c_mrv", 64'(mrv), 64'h1);
    chk("c_mra0", 64'(mra[0]), 64'hFF);
    chk("c_mwv", 64'(mwv), 64'h2);
    chk("c_mwa1", 64'(mwa[1]), 64'hF0);
    chk("c_mwd1", 64'(mwd[1]), 64'hF0);
    mwr[1] = 1'b1; mrr[0] = 1'b1; mrd[0] = 8'h11;
    tick();
    chk("c_cwr", 64'(cwr), 64'h02);
    chk("c_crr", 64'(crr), 64'h01);
    chk("c_crd0", 64'(crd[0]), 64'h11);
    chk("c_mwv_drop", 64'(mwv), 64'h0);
    crv[0] = 1'b0; cwv[1] = 1'b0; mwr[1] = 1'b0; mrr[0] = 1'b0;
    tick();
    chk("c_release_r", 64'(crr), 64'h0);
    chk("c_release_w", 64'(cwr), 64'h0);

    // Same slot read and write: rr pointer now 4, so requestors 6,7 go to ch0,ch1
    crv[3] = 1'b1; cra[3] = 8'h20;
    cwv[3] = 1'b1; cwa[3] = 8'h21; cwd[3] = 8'h5A;
    tick();
    chk("e_mrv", 64'(mrv), 64'h1);
    chk("e_mra0", 64'(mra[0]), 64'h20);
    chk("e_mwv", 64'(mwv), 64'h2);
    chk("e_mwa1", 64'(mwa[1]), 64'h21);
    chk("e_mwd1", 64'(mwd[1]), 64'h5A);
    mwr[1] = 1'b1;
    tick();
    chk("e_cwr", 64'(cwr), 64'h08);
    chk("e_crr_idle", 64'(crr), 64'h00);
    mwr[1] = 1'b0; mrr[0] = 1'b1; mrd[0] = 8'hA5;
    tick();
    chk("e_crr", 64'(crr), 64'h08);
    chk("e_crd3", 64'(crd[3]), 64'hA5);
    chk("e_cwr_hold", 64'(cwr), 64'h08);
    mrr[0] = 1'b0; cwv[3] = 1'b0;
    tick();
    chk("e_cwr_rel", 64'(cwr), 64'h00);
    chk("e_crr_hold", 64'(crr), 64'h08);
    crv[3] = 1'b0;
    tick();
    chk("e_crr_rel", 64'(crr), 64'h00);

    // Stalled memory: rr pointer 8 wraps to requestor 4 (slot2) on ch0
    crv[2] = 1'b1; cra[2] = 8'h40;
    tick();
    for (int n = 0; n < 20; n++) begin
      chk("f_stall_valid", 64'(mrv), 64'h1);
      chk("f_stall_addr", 64'(mra[0]), 64'h40);
      cra[2] = 8'(n);
      tick();
    end
    mrr[0] = 1'b1; mrd[0] = 8'h33;
    tick();
    chk("f_crr", 64'(crr), 64'h04);
    chk("f_crd2", 64'(crd[2]), 64'h33);
    mrr[0] = 1'b0; crv[2] = 1'b0;
    tick();
    chk("f_release", 64'(crr), 64'h00);

    // Oversubscription: all 8 slots read at once from a fresh pointer
    pulse_reset();
    for (int s = 0; s < 8; s++) cra[s] = 8'h80 + 8'(s);
    crv = 8'hFF;
    tick();
    chk("d_mrv1", 64'(mrv), 64'hF);
    chk("d_mra1", 64'(mra), 64'h83828180);
    tick();
    mrr = 4'hF; mrd = 32'hC3C2C1C0;
    tick();
    chk("d_crr1", 64'(crr), 64'h0F);
    chk("d_crd1", 64'(crd), 64'h00000000C3C2C1C0);
    chk("d_mrv1_drop", 64'(mrv), 64'h0);
    mrr = 4'h0; crv = 8'hF0;
    tick();
    chk("d_rel1", 64'(crr), 64'h00);
    tick();
    chk("d_mrv2", 64'(mrv), 64'hF);
    chk("d_mra2", 64'(mra), 64'h87868584);
    tick();
    mrr = 4'hF; mrd = 32'hD3D2D1D0;
    tick();
    chk("d_crr2", 64'(crr), 64'hF0);
    chk("d_crd2", 64'(crd), 64'hD3D2D1D0C3C2C1C0);
    mrr = 4'h0; crv = 8'h00;
    tick();
    chk("d_rel2", 64'(crr), 64'h00);
    chk("d_mrv_end", 64'(mrv), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dcache_mem_controller.md
Name: dcache_mem_controller

Overview:
- Sits directly downstream of dcache and services its per-consumer miss/writeback requests.
- Accepts read and write requests on NUM_CONSUMERS upstream slots, one slot per dcache consumer lane.
- Arbitrates them round-robin onto NUM_CHANNELS memory channels and relays read data and write completion back.
- Each channel carries one outstanding transaction through a 5-state FSM using valid/ready four-phase handshakes on both sides.

Parameters:
ADDR_BITS, 8, address width
DATA_BITS, 8, data width
NUM_CONSUMERS, 8, upstream request slots (dcache lanes)
NUM_CHANNELS, 4, concurrent memory channels; must satisfy 1 <= NUM_CHANNELS <= 2*NUM_CONSUMERS

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
consumer_read_valid  input  [NUM_CONSUMERS]  read request per slot
consumer_read_address  input  [NUM_CONSUMERS][ADDR_BITS]  read address
consumer_read_ready  output  [NUM_CONSUMERS]  read data valid / ack
consumer_read_data  output  [NUM_CONSUMERS][DATA_BITS]  returned read data
consumer_write_valid  input  [NUM_CONSUMERS]  write request per slot
consumer_write_address  input  [NUM_CONSUMERS][ADDR_BITS]  write address
consumer_write_data  input  [NUM_CONSUMERS][DATA_BITS]  write data
consumer_write_ready  output  [NUM_CONSUMERS]  write complete / ack
mem_read_valid  output  [NUM_CHANNELS]  read request to memory
mem_read_address  output  [NUM_CHANNELS][ADDR_BITS]  memory read address
mem_read_ready  input  [NUM_CHANNELS]  memory read data valid
mem_read_data  input  [NUM_CHANNELS][DATA_BITS]  memory read data
mem_write_valid  output  [NUM_CHANNELS]  write request to memory
mem_write_address  output  [NUM_CHANNELS][ADDR_BITS]  memory write address
mem_write_data  output  [NUM_CHANNELS][DATA_BITS]  memory write data
mem_write_ready  input  [NUM_CHANNELS]  memory write done

Behaviour:
- All outputs registered. While reset=0, asynchronously force all outputs to 0, every channel to IDLE, the claim mask to 0, and rr_ptr to 0.
- Requestors: 2*NUM_CONSUMERS requestors, indexed r=2i (read, slot i) and r=2i+1 (write, slot i).
  - A requestor is pending when its valid=1, its claim bit=0 and its ready output=0.
- Grant per edge:
  - Channels are evaluated in ascending index.
  - Each IDLE channel takes the first pending, not-yet-taken requestor scanning from rr_ptr upward, with wrap.
  - The granted requestor's claim bit is set, and that channel latches the address (and data for writes).
  - rr_ptr becomes (last granted r)+1 mod 2*NUM_CONSUMERS. It is unchanged if nothing was granted.
- Channel FSM:
  - IDLE -> READ_WAITING on a read grant: mem_read_valid=1, mem_read_address=latched address.
  - IDLE -> WRITE_WAITING on a write grant: mem_write_valid=1, with address and data.
  - READ_WAITING, on mem_read_ready=1 -> READ_RELAYING: mem_read_valid=0, consumer_read_ready[i]=1, consumer_read_data[i]=mem_read_data.
  - WRITE_WAITING, on mem_write_ready=1 -> WRITE_RELAYING: mem_write_valid=0, consumer_write_ready[i]=1.
  - *_RELAYING, on the matching consumer valid=0 -> IDLE: ready[i]=0, claim bit cleared, consumer_read_data[i] holds its value.
  - A channel returning to IDLE may be granted no earlier than the following edge.
- Latency (unloaded read): request seen at edge 0 -> mem_read_valid at edge 0. Memory ready at edge k -> consumer_read_ready at edge k. Release one edge after the consumer drops valid.
- The same slot may hold a read and a write concurrently on different channels. No ordering between them is guaranteed; dcache is responsible for hazards.
- Waiting states never time out.
- Address/data inputs are sampled only at grant; later changes while claimed are ignored.
- Valid drop in *_WAITING: the consumer must not drop valid while waiting. If it does, complete the memory transaction, enter RELAYING, then return to IDLE on the next edge.
- More pending requestors than channels: excess requestors wait. Round-robin guarantees any continuously pending requestor is granted within 2*NUM_CONSUMERS grants.
- Reset asserted mid-transaction: outstanding memory requests are dropped (valids go to 0 immediately). Memory must tolerate an abandoned request.

Test Plan:
- Reset mid-operation → outputs zero while asserted.
  - Stimulus: reset=0, then 1.
  - Read slot0 addr 0x10, hold reset=0 during WAITING.
  - Required: mem_read_valid=0 immediately.
  - After release, re-request is granted on channel0 with rr_ptr=0.
- Single read, read-relay timing.
  - Stimulus: slot0 read 0xFF; mem_read_ready[0]=1 with data 0xFF one cycle later.
  - Required: mem_read_valid[0]=1 with addr 0xFF.
  - Then consumer_read_ready[0]=1 with data 0xFF and mem_read_valid[0]=0.
  - Consumer drops valid → ready=0 next edge.
- Concurrent read and write (mirrors dcache Test 0).
  - Stimulus: slot0 read 0xFF and slot1 write 0xF0/data 0xF0 in the same cycle.
  - Required: channel0 read 0xFF, channel1 write 0xF0/0xF0.
  - mem_write_ready[1] → consumer_write_ready[1]=1.
- Oversubscription / round-robin.
  - Stimulus: all 8 slots issue reads together; each memory channel answers after 2 cycles.
  - Required first grants: requestors 0,2,4,6 on channels 0-3.
  - Next grants start at requestor 8 (slot4); all 8 reads complete with the correct per-slot data.
- Same slot read and write.
  - Stimulus: slot3 read 0x20 and write 0x21/0x5A.
  - Required: granted on two distinct channels; both acks return independently.
  - No other slot's ready toggles.
- Stalled memory.
  - Stimulus: mem_read_ready held 0 for 20 cycles, then 1 with 0x33.
  - Required: mem_read_valid stays 1 and the address is stable for all 20 cycles.
  - Then consumer_read_data=0x33.
